// File: rtl/ndp_drain_pkg.sv
// Shared types and geometry helpers for the NDP result drain.
// The state type uses plain constants so legacy code can compare against raw encodings.
package ndp_drain_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t DRAIN = 2'd1;
    localparam state_t CLEAR = 2'd2;

    function automatic int calc_rows(input int sys_height, input int arr_height);
        return sys_height * arr_height;
    endfunction

    function automatic int calc_cols(input int sys_width, input int arr_width);
        return sys_width * arr_width;
    endfunction

    // A single row still needs a 1-bit index port.
    function automatic int calc_idxw(input int rows);
        return (rows <= 1) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/ndp_result_drain.sv
// Snapshots NDP_unit out_c on the calc_done edge, streams it row by row over valid/ready,
// then pulses clear_req. Optional feature macro: DRAIN_CHECKSUM_EN (adds out_checksum).
module ndp_result_drain
    import ndp_drain_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 1,
    localparam int ROWS = calc_rows(SYS_HEIGHT, ARR_HEIGHT),
    localparam int COLS = calc_cols(SYS_WIDTH, ARR_WIDTH),
    localparam int IDXW = calc_idxw(ROWS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          calc_done_flag,
    input  logic [ROWS*COLS*WIDTH-1:0]    in_c,
    output logic [COLS*WIDTH-1:0]         out_row,
    output logic [IDXW-1:0]               out_row_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic                          clear_req,
    output logic                          err_overrun
`ifdef DRAIN_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]              out_checksum
`endif
);

    localparam int              ROW_W    = COLS * WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWS - 1);

    state_t                     state;
    logic                       done_q;
    logic                       start;
    logic                       fire;
    logic [IDXW-1:0]            idx;
    logic [ROWS*ROW_W-1:0]      snapshot;
    logic                       err_q;
    logic [ROW_W-1:0]           row_sel;

    assign start   = calc_done_flag && !done_q;
    assign row_sel = snapshot[int'(idx)*ROW_W +: ROW_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            idx      <= '0;
            snapshot <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= calc_done_flag;
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= in_c;
                        idx      <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        if (idx == LAST_IDX) begin
                            state <= CLEAR;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
            // A done edge while a job is in flight is dropped; the snapshot is never overwritten.
            if (start && (state != IDLE)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid   = (state == DRAIN);
    assign fire        = out_valid && out_ready;
    assign out_last    = out_valid && (idx == LAST_IDX);
    assign out_row_idx = idx;
    assign out_row     = out_valid ? row_sel : '0;
    assign busy        = (state != IDLE);
    assign clear_req   = (state == CLEAR);
    assign err_overrun = err_q;

`ifdef DRAIN_CHECKSUM_EN
    logic [WIDTH-1:0] cks_acc;

    function automatic logic [WIDTH-1:0] fold_row(input logic [ROW_W-1:0] row);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            acc ^= row[c*WIDTH +: WIDTH];
        end
        return acc;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cks_acc <= '0;
        end else if ((state == IDLE) && start) begin
            cks_acc <= '0;
        end else if (fire) begin
            cks_acc <= cks_acc ^ fold_row(row_sel);
        end
    end

    // Folding in the row on display makes the value complete on the last beat itself.
    assign out_checksum = cks_acc ^ fold_row(out_row);
`endif

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed + randomized bench for ndp_result_drain (4x4, WIDTH=16), matrix/beat-count reference model.
// Build with DRAIN_CHECKSUM_EN defined to also check out_checksum.
module tb_ndp_result_drain;

    localparam int WIDTH = 16;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int IDXW  = 2;
    localparam int ROW_W = COLS * WIDTH;
    localparam int BUDGET = 200;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     calc_done_flag;
    logic [ROWS*ROW_W-1:0]    in_c;
    logic [ROW_W-1:0]         out_row;
    logic [IDXW-1:0]          out_row_idx;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     clear_req;
    logic                     err_overrun;
`ifdef DRAIN_CHECKSUM_EN
    logic [WIDTH-1:0]         out_checksum;
`endif

    int total = 0;
    int bad   = 0;
    int pat_pos;
    int ready_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [WIDTH-1:0] mat [ROWS][COLS];

    always #5 clk = ~clk;

    ndp_result_drain #(
        .WIDTH      (WIDTH),
        .ARR_HEIGHT (4),
        .ARR_WIDTH  (4),
        .SYS_HEIGHT (1),
        .SYS_WIDTH  (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .calc_done_flag (calc_done_flag),
        .in_c           (in_c),
        .out_row        (out_row),
        .out_row_idx    (out_row_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .clear_req      (clear_req),
        .err_overrun    (err_overrun)
`ifdef DRAIN_CHECKSUM_EN
        ,
        .out_checksum   (out_checksum)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROWS*ROW_W-1:0] pack_mat();
        logic [ROWS*ROW_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS + c)*WIDTH +: WIDTH] = mat[r][c];
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*WIDTH +: WIDTH] = mat[r][c];
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] exp_cks();
        logic [WIDTH-1:0] x;
        x = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) x ^= mat[r][c];
        return x;
    endfunction

    task automatic fill(input int random_data);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mat[r][c] = random_data ? WIDTH'($urandom) : WIDTH'(16'h0100 * r + c);
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return ready_pat[pat_pos % 7] != 0;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 128'(out_valid), 128'(0));
        chk({tag, ".clear"}, 128'(clear_req), 128'(0));
        chk({tag, ".busy"},  128'(busy),      128'(0));
    endtask

    // Raises done with the current matrix and follows the job to its clear cycle.
    // glitch: drop done on row 1 and re-raise it with all-ones data on row 2.
    task automatic run_job(input string tag, input int ready_mode, input int glitch, input logic exp_err);
        int beat;
        int cycles;
        logic rdy;
        beat    = 0;
        cycles  = 0;
        pat_pos = 0;
        in_c = pack_mat();
        calc_done_flag = 1'b1;
        step();
        while (beat <= ROWS && cycles < BUDGET) begin
            cycles++;
            if (beat < ROWS) begin
                chk({tag, ".valid"}, 128'(out_valid), 128'(1));
                chk({tag, ".idx"},   128'(out_row_idx), 128'(beat));
                chk({tag, ".row"},   128'(out_row), 128'(exp_row(beat)));
                chk({tag, ".last"},  128'(out_last), 128'(beat == ROWS - 1));
                chk({tag, ".busy"},  128'(busy), 128'(1));
                chk({tag, ".clear"}, 128'(clear_req), 128'(0));
`ifdef DRAIN_CHECKSUM_EN
                if (beat == ROWS - 1) chk({tag, ".cks"}, 128'(out_checksum), 128'(exp_cks()));
`endif
                if (glitch != 0 && beat == 1) calc_done_flag = 1'b0;
                if (glitch != 0 && beat == 2) begin
                    calc_done_flag = 1'b1;
                    in_c = '1;
                end
                rdy = pick_ready(ready_mode);
                pat_pos++;
                out_ready = rdy;
                step();
                if (rdy) beat++;
            end else begin
                chk({tag, ".cvalid"}, 128'(out_valid), 128'(0));
                chk({tag, ".cclear"}, 128'(clear_req), 128'(1));
                chk({tag, ".cbusy"},  128'(busy), 128'(1));
                step();
                beat++;
            end
        end
        chk({tag, ".budget"}, 128'(cycles < BUDGET), 128'(1));
        check_idle({tag, ".after"});
        chk({tag, ".err"}, 128'(err_overrun), 128'(exp_err));
        out_ready = 1'b0;
    endtask

    task automatic drop_done();
        calc_done_flag = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        calc_done_flag = 1'b0;
        out_ready = 1'b0;
        in_c = '0;
        step();
        step();
        chk("rst.valid", 128'(out_valid), 128'(0));
        chk("rst.last",  128'(out_last), 128'(0));
        chk("rst.idx",   128'(out_row_idx), 128'(0));
        chk("rst.row",   128'(out_row), 128'(0));
        chk("rst.busy",  128'(busy), 128'(0));
        chk("rst.clear", 128'(clear_req), 128'(0));
        chk("rst.err",   128'(err_overrun), 128'(0));
        reset_n = 1'b1;
        step();
        check_idle("idle0");

        fill(0);
        run_job("t1", 0, 0, 1'b0);
        drop_done();

        run_job("t2", 2, 0, 1'b0);
        drop_done();

        // Done held high long after the job: it must not retrigger.
        fill(1);
        run_job("t3", 0, 0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            check_idle("t3.hold");
            step();
        end
        chk("t3.err", 128'(err_overrun), 128'(0));
        drop_done();

        for (int j = 0; j < 6; j++) begin
            fill(1);
            run_job("rnd", 1, 0, 1'b0);
            drop_done();
        end

        fill(0);
        run_job("t4", 0, 1, 1'b1);
        drop_done();
        check_idle("t4.idle");

        // Reset in the middle of row 1.
        fill(1);
        in_c = pack_mat();
        calc_done_flag = 1'b1;
        step();
        out_ready = 1'b1;
        step();
        chk("t5.idx1", 128'(out_row_idx), 128'(1));
        reset_n = 1'b0;
        calc_done_flag = 1'b0;
        step();
        chk("t5.valid", 128'(out_valid), 128'(0));
        chk("t5.idx",   128'(out_row_idx), 128'(0));
        chk("t5.clear", 128'(clear_req), 128'(0));
        chk("t5.err",   128'(err_overrun), 128'(0));
        reset_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("t5.quiet");
            step();
        end
        run_job("t5.job", 0, 0, 1'b0);
        drop_done();

        fill(0);
        mat[3][3] = 16'h1234;
        run_job("t6", 0, 0, 1'b0);
        drop_done();

        for (int j = 0; j < 4; j++) begin
            fill(1);
            run_job("rnd2", 1, 0, 1'b0);
            drop_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
